// File: rtl/fir_cfg_pkg.sv
// Shared types for the FIR output-scale configuration master:
// FSM states, default config width and the queued request record.
package fir_cfg_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, NEXT} cfgState_t;

  localparam int CFG_W_DEFAULT = 24;
  localparam int TGT_W = 4;

  typedef struct packed {
    logic                     bcast;
    logic [TGT_W-1:0]         tgt;
    logic [CFG_W_DEFAULT-1:0] data;
  } cfgReq_t;

endpackage

// File: rtl/cfg_req_fifo.sv
// Small synchronous request queue; the head word is visible combinationally
// and is consumed by a pop.
module cfg_req_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wrPtr;
  logic [PTR_W:0]   rdPtr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                    (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  assign headData = mem[rdPtr[PTR_W-1:0]];

  always_ff @(posedge CLK) begin
    if (push && !full) begin
      mem[wrPtr[PTR_W-1:0]] <= pushData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop && !empty) begin
        rdPtr <= rdPtr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_scale_cfg_master.sv
// Configuration initiator for the FIR output-scale targets: queues host
// requests and runs the isConfig / isConfigDone handshake one at a time.
module fir_scale_cfg_master
  import fir_cfg_pkg::*;
#(
  parameter int NUM_TGT    = 4,
  parameter int CFG_W      = CFG_W_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Req_Valid,
  output logic               Req_Ready,
  input  logic [3:0]         Req_Tgt,
  input  logic               Req_Bcast,
  input  logic [CFG_W-1:0]   Req_Data,
  output logic [NUM_TGT-1:0] isConfig,
  output logic [CFG_W-1:0]   Data_Config_Out,
  input  logic [NUM_TGT-1:0] isConfigDone,
  input  logic [NUM_TGT-1:0] isConfigACK,
  output logic               Busy,
  output logic               Cfg_Done_Pulse,
  output logic               Err_Timeout,
  output logic               Err_BadTgt,
  output logic [3:0]         Err_Tgt,
  input  logic               Err_Clr,
  output logic [15:0]        Done_Cnt
);

  localparam int REQ_W = 1 + TGT_W + CFG_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  cfgState_t        state, stateNext;
  logic [TGT_W-1:0] idx, idxNext;
  logic             bcastReg, bcastNext;
  logic [CFG_W-1:0] dataReg, dataNext;
  logic [TMR_W-1:0] timer, timerNext;

  logic             fifoFull, fifoEmpty, fifoPop;
  logic [REQ_W-1:0] fifoHead;
  logic             headBcast;
  logic [TGT_W-1:0] headTgt;
  logic [CFG_W-1:0] headData;

  logic             doneSel;
  logic             setTimeout, setBadTgt, cfgDone;
  logic             unusedAck;

  // Acks are informational only; completion is judged on Done alone.
  assign unusedAck = ^isConfigACK;

  cfg_req_fifo #(
    .WIDTH(REQ_W),
    .DEPTH(FIFO_DEPTH)
  ) reqFifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (Req_Valid && Req_Ready),
    .pushData({Req_Bcast, Req_Tgt, Req_Data}),
    .pop     (fifoPop),
    .headData(fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  assign headBcast       = fifoHead[REQ_W-1];
  assign headTgt         = fifoHead[CFG_W +: TGT_W];
  assign headData        = fifoHead[CFG_W-1:0];
  assign Req_Ready       = !fifoFull;
  assign Busy            = (state != IDLE) || !fifoEmpty;
  assign Data_Config_Out = dataReg;
  assign Cfg_Done_Pulse  = cfgDone;

  always_comb begin
    isConfig = '0;
    doneSel  = 1'b0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (idx == TGT_W'(i)) begin
        isConfig[i] = (state == PULSE);
        doneSel     = isConfigDone[i];
      end
    end
  end

  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    bcastNext  = bcastReg;
    dataNext   = dataReg;
    timerNext  = timer;
    fifoPop    = 1'b0;
    setTimeout = 1'b0;
    setBadTgt  = 1'b0;
    cfgDone    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          if (!headBcast && ({1'b0, headTgt} >= 5'(NUM_TGT))) begin
            setBadTgt = 1'b1;
          end else begin
            dataNext  = headData;
            bcastNext = headBcast;
            idxNext   = headBcast ? '0 : headTgt;
            stateNext = PULSE;
          end
        end
      end
      PULSE: begin
        timerNext = '0;
        stateNext = WAIT;
      end
      WAIT: begin
        if (doneSel) begin
          stateNext = NEXT;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          setTimeout = 1'b1;
          stateNext  = IDLE;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      NEXT: begin
        if (bcastReg && ({1'b0, idx} < 5'(NUM_TGT - 1))) begin
          idxNext   = idx + 1'b1;
          stateNext = PULSE;
        end else begin
          cfgDone   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Sticky error flags: a set in the same cycle as Err_Clr takes priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      idx         <= '0;
      bcastReg    <= 1'b0;
      dataReg     <= '0;
      timer       <= '0;
      Done_Cnt    <= '0;
      Err_Timeout <= 1'b0;
      Err_BadTgt  <= 1'b0;
      Err_Tgt     <= '0;
    end else begin
      state    <= stateNext;
      idx      <= idxNext;
      bcastReg <= bcastNext;
      dataReg  <= dataNext;
      timer    <= timerNext;
      if (cfgDone) begin
        Done_Cnt <= Done_Cnt + 16'd1;
      end
      if (setTimeout) begin
        Err_Timeout <= 1'b1;
        Err_Tgt     <= idx;
      end else if (Err_Clr) begin
        Err_Timeout <= 1'b0;
        Err_Tgt     <= '0;
      end
      if (setBadTgt) begin
        Err_BadTgt <= 1'b1;
      end else if (Err_Clr) begin
        Err_BadTgt <= 1'b0;
      end
    end
  end

endmodule
